// File: rtl/quant_pkg.sv
// Shared widths and reset defaults for the streaming requantizer.
// Optional round-half-up before shifting is enabled by QUANT_ROUND_EN.
package quant_pkg;

  localparam int DEF_ACC_W   = 18;
  localparam int DEF_MID_W   = 16;
  localparam int DEF_SCALE_W = 16;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_NCH     = 4;

  localparam int RST_SCALE = 1;
  localparam int RST_SHIFT = 0;
  localparam int RST_ZP    = 0;

  localparam int CNT_W = 16;

endpackage

// File: rtl/quant_stream_sat_signed.sv
// Signed saturator: narrows IN_W to OUT_W, flags clipping.
// Narrower inputs are sign-extended and never flag.
module sat_signed #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  if (IN_W > OUT_W) begin : g_sat
    logic [IN_W-OUT_W:0] hi;

    assign hi = din[IN_W-1:OUT_W-1];

    // in range when all bits above the output msb match the sign
    always_comb begin
      dout = din[OUT_W-1:0];
      sat  = 1'b0;
      if (!(&hi || ~|hi)) begin
        sat = 1'b1;
        if (din[IN_W-1])
          dout = {1'b1, {(OUT_W-1){1'b0}}};
        else
          dout = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end else begin : g_ext
    assign dout = OUT_W'(din);
    assign sat  = 1'b0;
  end

endmodule

// File: rtl/quant_stream.sv
// Three-stage streaming requantizer with per-channel scale/shift/zp.
// Define QUANT_ROUND_EN to build round-half-up before the shift.
module quant_stream
  import quant_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MID_W   = DEF_MID_W,
  parameter int SCALE_W = DEF_SCALE_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int NCH     = DEF_NCH,
  parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_acc,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_q,
  output logic [CH_W-1:0]    out_ch,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [OUT_W-1:0]   cfg_zp,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam int P_W = MID_W + SCALE_W;

  logic signed [SCALE_W-1:0] tbl_scale [NCH];
  logic [SHIFT_W-1:0]        tbl_shift [NCH];
  logic [OUT_W-1:0]          tbl_zp    [NCH];

  logic advance;
  logic cfg_ok;
  logic in_ok;
  logic [CH_W-1:0] tidx;

  logic                      v1;
  logic signed [MID_W-1:0]   mid1;
  logic signed [SCALE_W-1:0] scale1;
  logic [SHIFT_W-1:0]        shift1;
  logic [OUT_W-1:0]          zp1;
  logic [CH_W-1:0]           ch1;
  logic                      f1;

  logic                      v2;
  logic signed [P_W-1:0]     s2;
  logic [OUT_W-1:0]          zp2;
  logic [CH_W-1:0]           ch2;
  logic                      f2;

  logic                      flag3;

  logic signed [MID_W-1:0]   mid0;
  logic                      sat0;
  logic signed [P_W-1:0]     prod;
  logic signed [P_W-1:0]     prod_r;
  logic signed [P_W-1:0]     shv;
  logic signed [OUT_W-1:0]   t3;
  logic                      sat3;
  logic signed [OUT_W+1:0]   u3;
  logic [OUT_W-1:0]          q3;
  logic                      clamp3;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign cfg_ok   = {1'b0, cfg_ch} < (CH_W+1)'(NCH);
  assign in_ok    = {1'b0, in_ch} < (CH_W+1)'(NCH);
  assign tidx     = in_ok ? in_ch : '0;

  sat_signed #(.IN_W(ACC_W), .OUT_W(MID_W)) u_sat1 (
    .din  (in_acc),
    .dout (mid0),
    .sat  (sat0)
  );

  // parameter table; writes land after any same-cycle S1 capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        tbl_scale[i] <= SCALE_W'(RST_SCALE);
        tbl_shift[i] <= SHIFT_W'(RST_SHIFT);
        tbl_zp[i]    <= OUT_W'(RST_ZP);
      end
    end else if (cfg_we && cfg_ok) begin
      tbl_scale[cfg_ch] <= cfg_scale;
      tbl_shift[cfg_ch] <= cfg_shift;
      tbl_zp[cfg_ch]    <= cfg_zp;
    end
  end

  // S1: saturate accumulator, latch channel parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      mid1   <= '0;
      scale1 <= '0;
      shift1 <= '0;
      zp1    <= '0;
      ch1    <= '0;
      f1     <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        mid1   <= mid0;
        scale1 <= tbl_scale[tidx];
        shift1 <= tbl_shift[tidx];
        zp1    <= tbl_zp[tidx];
        ch1    <= in_ch;
        f1     <= sat0;
      end
    end
  end

  // S2 datapath: full-precision product, optional rounding, shift
  always_comb begin
    prod   = P_W'(mid1) * P_W'(scale1);
    prod_r = prod;
`ifdef QUANT_ROUND_EN
    if (shift1 != '0)
      prod_r = prod + (P_W'(1) << (shift1 - 1'b1));
`endif
    shv = prod_r >>> shift1;
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      s2  <= '0;
      zp2 <= '0;
      ch2 <= '0;
      f2  <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        s2  <= shv;
        zp2 <= zp1;
        ch2 <= ch1;
        f2  <= f1;
      end
    end
  end

  sat_signed #(.IN_W(P_W), .OUT_W(OUT_W)) u_sat3 (
    .din  (s2),
    .dout (t3),
    .sat  (sat3)
  );

  // S3 datapath: add zero point, clamp to unsigned range
  always_comb begin
    u3     = (OUT_W+2)'(t3) + $signed({2'b00, zp2});
    q3     = u3[OUT_W-1:0];
    clamp3 = 1'b0;
    if (u3[OUT_W+1]) begin
      q3     = '0;
      clamp3 = 1'b1;
    end else if (u3[OUT_W]) begin
      q3     = '1;
      clamp3 = 1'b1;
    end
  end

  // S3 register drives the output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_ch    <= '0;
      flag3     <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        out_q  <= q3;
        out_ch <= ch2;
        flag3  <= f2 | sat3 | clamp3;
      end
    end
  end

  // saturation counter: clear wins, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (out_valid && out_ready && flag3 && !(&sat_cnt))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_quant_stream.sv
// Directed self-checking bench for quant_stream.
// Rounding expectations follow QUANT_ROUND_EN.
module tb_quant_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_acc;
  logic [1:0]  in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_q;
  logic [1:0]  out_ch;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_zp;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  int n_cmp;
  int n_bad;

`ifdef QUANT_ROUND_EN
  localparam logic [7:0] EXP_R_POS = 8'd2;
  localparam logic [7:0] EXP_R_NEG = 8'd9;
`else
  localparam logic [7:0] EXP_R_POS = 8'd1;
  localparam logic [7:0] EXP_R_NEG = 8'd8;
`endif

  quant_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_ch    (out_ch),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input logic [1:0] ch, input logic [15:0] sc,
                         input logic [4:0] sh, input logic [7:0] zp);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_scale = sc;
    cfg_shift = sh;
    cfg_zp    = zp;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_one(input logic [17:0] acc, input logic [1:0] ch,
                          output logic [7:0] q, output logic [1:0] och,
                          output int lat);
    in_valid = 1'b1;
    in_acc   = acc;
    in_ch    = ch;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    q   = out_q;
    och = out_ch;
    if (!out_valid) begin
      lat = 99;
      q   = 8'h00;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (sat_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_q !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_out_q got %0d want 0", out_q);
    end
  endtask

  task automatic test_default;
    logic [7:0] q;
    logic [1:0] c;
    int lat;
    send_one(18'd5, 2'd0, q, c, lat);
    n_cmp++;
    if (q !== 8'd5) begin
      n_bad++;
      $display("FAIL default_q got %0d want 5", q);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL default_latency got %0d want 3", lat);
    end
    n_cmp++;
    if (c !== 2'd0) begin
      n_bad++;
      $display("FAIL default_ch got %0d want 0", c);
    end
  endtask

  task automatic test_scaling;
    logic [7:0] q;
    logic [1:0] c;
    int lat;
    set_cfg(2'd1, 16'd20000, 5'd15, 8'd128);
    send_one(18'd100, 2'd1, q, c, lat);
    n_cmp++;
    if (q !== 8'd189) begin
      n_bad++;
      $display("FAIL scale_q got %0d want 189", q);
    end
    n_cmp++;
    if (c !== 2'd1) begin
      n_bad++;
      $display("FAIL scale_ch got %0d want 1", c);
    end
    n_cmp++;
    if (sat_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL scale_sat_cnt got %0d want 0", sat_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] q;
    logic [1:0] c;
    int lat;
    send_one(18'sd131071, 2'd0, q, c, lat);
    n_cmp++;
    if (q !== 8'd127) begin
      n_bad++;
      $display("FAIL sat_pos_q got %0d want 127", q);
    end
    n_cmp++;
    if (sat_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL sat_pos_cnt got %0d want 1", sat_cnt);
    end
    send_one(-18'sd131072, 2'd0, q, c, lat);
    n_cmp++;
    if (q !== 8'd0) begin
      n_bad++;
      $display("FAIL sat_neg_q got %0d want 0", q);
    end
    n_cmp++;
    if (sat_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL sat_neg_cnt got %0d want 2", sat_cnt);
    end
    sat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL sat_clr got %0d want 0", sat_cnt);
    end
  endtask

  task automatic test_rounding;
    logic [7:0] q;
    logic [1:0] c;
    int lat;
    set_cfg(2'd3, 16'd1, 5'd1, 8'd0);
    send_one(18'd3, 2'd3, q, c, lat);
    n_cmp++;
    if (q !== EXP_R_POS) begin
      n_bad++;
      $display("FAIL round_pos got %0d want %0d", q, EXP_R_POS);
    end
    set_cfg(2'd3, 16'd1, 5'd1, 8'd10);
    send_one(-18'sd3, 2'd3, q, c, lat);
    n_cmp++;
    if (q !== EXP_R_NEG) begin
      n_bad++;
      $display("FAIL round_neg got %0d want %0d", q, EXP_R_NEG);
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] got [8];
    logic [7:0] held;
    logic       was_stall;
    int n;
    int sent;
    n = 0;
    sent = 0;
    was_stall = 1'b0;
    held = 8'h00;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      #1;
      if (out_valid && out_ready) begin
        got[n] = out_q;
        n++;
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, in_ready);
        end
        if (was_stall) begin
          n_cmp++;
          if (out_q !== held) begin
            n_bad++;
            $display("FAIL bp_hold cyc %0d got %0d want %0d", cyc, out_q, held);
          end
        end
        held = out_q;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      in_valid = (sent < 8);
      in_acc   = 18'(10 + sent);
      in_ch    = 2'd0;
      if (in_valid && in_ready)
        sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (n !== 8) begin
      n_bad++;
      $display("FAIL bp_count got %0d want 8", n);
    end
    for (int i = 0; i < n && i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 8'(10 + i)) begin
        n_bad++;
        $display("FAIL bp_order idx %0d got %0d want %0d", i, got[i], 10 + i);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cfg_race;
    logic [7:0] q [2];
    logic [1:0] c [2];
    int n;
    cfg_we    = 1'b1;
    cfg_ch    = 2'd2;
    cfg_scale = 16'd1;
    cfg_shift = 5'd0;
    cfg_zp    = 8'd50;
    in_valid  = 1'b1;
    in_acc    = 18'd1;
    in_ch     = 2'd2;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && n < 2; i++) begin
      if (out_valid) begin
        q[n] = out_q;
        c[n] = out_ch;
        n++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL race_count got %0d want 2", n);
    end else begin
      n_cmp++;
      if (q[0] !== 8'd1) begin
        n_bad++;
        $display("FAIL race_old got %0d want 1", q[0]);
      end
      n_cmp++;
      if (q[1] !== 8'd51) begin
        n_bad++;
        $display("FAIL race_new got %0d want 51", q[1]);
      end
      n_cmp++;
      if (c[1] !== 2'd2) begin
        n_bad++;
        $display("FAIL race_ch got %0d want 2", c[1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    logic [7:0] q;
    logic [1:0] c;
    int lat;
    int seen;
    in_valid = 1'b1;
    in_ch    = 2'd2;
    for (int i = 0; i < 3; i++) begin
      in_acc = 18'(20 + i);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mrst_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_q !== 8'd0) begin
      n_bad++;
      $display("FAIL mrst_out_q got %0d want 0", out_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid)
        seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mrst_ghost got %0d want 0", seen);
    end
    send_one(18'd1, 2'd2, q, c, lat);
    n_cmp++;
    if (q !== 8'd1) begin
      n_bad++;
      $display("FAIL mrst_table got %0d want 1", q);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_ch     = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_scale = '0;
    cfg_shift = '0;
    cfg_zp    = '0;
    sat_clr   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_default;
    test_scaling;
    test_saturation;
    test_rounding;
    test_back_pressure;
    test_cfg_race;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quant_stream.md
# quant_stream

Streaming, multi-channel successor to the fixed int18→int8 requantizer. Takes signed accumulator results with a channel tag, saturates them to an intermediate width, multiplies by a per-channel scale, arithmetic-right-shifts with optional rounding, saturates to signed output width, and adds a per-channel zero point with unsigned clamping. It sits between the MAC array accumulators and the activation write-back buffer, with valid/ready flow control on both sides and a runtime-writable per-channel parameter table.

## Interface
- ACC_W, 18, signed accumulator input width
- MID_W, 16, signed intermediate width after first saturation
- SCALE_W, 16, signed scale width
- SHIFT_W, 5, shift amount width; shift < MID_W+SCALE_W
- OUT_W, 8, output width; the zero point is also OUT_W wide
- NCH, 4, number of channels in the parameter table (≥1)
- CH_W, $clog2(NCH) (min 1), channel index width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_acc  in  ACC_W  signed accumulator value
- in_ch  in  CH_W  channel index for this beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_q  out  OUT_W  unsigned quantized result
- out_ch  out  CH_W  channel index carried with the beat
- cfg_we  in  1  parameter table write strobe
- cfg_ch  in  CH_W  table entry to write
- cfg_scale  in  SCALE_W  signed scale
- cfg_shift  in  SHIFT_W  right-shift amount
- cfg_zp  in  OUT_W  unsigned zero point
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  16  count of output beats with any saturation/clamp

## Operation
- Stage S1 (on accept): mid = sat_signed(in_acc, MID_W); capture table[in_ch] (scale, shift, zp) and in_ch alongside the data; flag f1 = saturation occurred.
- Stage S2: p = mid * scale (MID_W+SCALE_W signed, full precision); if rounding enabled and shift>0, p += 1<<(shift-1); s = p >>> shift (arithmetic).
- Stage S3: t = sat_signed(s, OUT_W); u = t + zp in OUT_W+2 signed bits; out_q = clamp(u, 0, 2^OUT_W−1). Flag f3 = S3 saturation or clamp. Beat flag = f1 | f2(none) | f3.
- Parameter table: NCH registers. Reset values: scale = 1, shift = 0, zp = 0 for every channel. cfg_we writes entry cfg_ch at the clock edge; cfg_ch ≥ NCH is ignored.
- Table sampling at S1: write and input accepted in the same cycle on the same channel → the beat uses the old value; beats already in flight are never affected.
- in_ch ≥ NCH: beat uses entry 0 and passes in_ch through unchanged on out_ch.
- sat_cnt: increments by 1 when out_valid && out_ready && beat flag; saturates at 0xFFFF; sat_clr has priority over an increment in the same cycle (result 0).

## Timing
- Latency: 3 cycles from input accept to out_valid when unstalled; throughput 1 beat/cycle.
- Pipeline advance: advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready; no skid buffer). All three stages hold while stalled.
- out_q and out_ch hold stable while out_valid && !out_ready.
- Reset (rst_n low, any time, including mid-stream): all stage valids 0, out_valid 0, out_q 0, out_ch 0, sat_cnt 0, table to reset values; in-flight beats are discarded. in_ready is 1 during and after reset.
- No combinational path from in_valid to out_valid.

## Configuration
- QUANT_ROUND_EN defined: round-half-up before shifting (adds 1<<(shift−1) when shift>0).
- QUANT_ROUND_EN undefined: pure arithmetic-shift truncation (floor); the rounding adder is not built. Latency unchanged in both cases.

## Structure
- Package quant_pkg: default width constants (ACC_W, MID_W, SCALE_W, SHIFT_W, OUT_W), reset parameter values (scale 1, shift 0, zp 0), sat_cnt width 16.
- One sub-module: sat_signed (parameterised IN_W/OUT_W signed saturator with saturation flag output), instantiated for S1 and S3.

## Test plan
- Reset values: after reset, out_valid=0, sat_cnt=0, in_ready=1; in_acc=5, ch 0 → out_q=5 after 3 cycles.
- Scaling: ch 1 set to scale=20000, shift=15, zp=128; in_acc=100 → out_q=189 (61+128), no sat_cnt increment.
- Saturation: ch 0 defaults, in_acc=131071 → out_q=127, sat_cnt=1; in_acc=−131072 → −128 → clamped to out_q=0, sat_cnt=2; sat_clr → 0.
- Rounding: scale=1, shift=1; in_acc=3 → 2 (QUANT_ROUND_EN) / 1 (undefined); in_acc=−3 → −1 / −2, with zp=10 → 9 / 8.
- Back-pressure: stream 8 beats, hold out_ready low for 5 cycles mid-stream → in_ready low during the stall, no loss or duplication, outputs in order, out_q stable while stalled.
- Config race and mid-stream reset: write ch 2 zp 0→50 in the same cycle a ch 2 beat (in_acc=1) is accepted → that beat out_q=1, the next → 51; assert rst_n low with 3 beats in flight → no output beats after release.
